cc_in_collector: RTL and testbench

Serial-to-parallel input stage placed directly upstream of the CC combinational sort/normalise/equation core. It accepts one 4-bit operand per handshake beat, plus the `opt`/`equ` command on the first beat. After six operands it presents a stable parallel bundle (`n0..n5`, `opt`, `equ`) that drives CC's inputs, and holds it until the consumer acknowledges.

---
 rtl/cc_pkg.sv | 16 +
 rtl/cc_in_collector_if.sv | 36 +++
 rtl/cc_gap_timer.sv | 36 +++
 rtl/cc_in_collector.sv | 163 ++++++++++++++++
 tb/tb_cc_in_collector.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cc_pkg.sv
// Shared definitions for the CC input collector and CC-side benches.
// Operand count, field widths and the collector state encoding.
package cc_pkg;

    localparam int unsigned NUM_OF_ELEMENT = 6;
    localparam int unsigned NIBBLE_W       = 4;
    localparam int unsigned OPT_W          = 3;
    localparam int unsigned CNT_W          = 3;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StHold
    } cc_in_state_t;

endpackage

// File: rtl/cc_in_collector_if.sv
// Beat input and parallel bundle output of the CC input collector.
// master = upstream source plus consumer side; slave = the collector.
interface cc_in_collector_if;
    import cc_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [NIBBLE_W-1:0] in_data;
    logic [OPT_W-1:0]    in_opt;
    logic                in_equ;

    logic                out_valid;
    logic                out_ready;
    logic [NIBBLE_W-1:0] out_n0;
    logic [NIBBLE_W-1:0] out_n1;
    logic [NIBBLE_W-1:0] out_n2;
    logic [NIBBLE_W-1:0] out_n3;
    logic [NIBBLE_W-1:0] out_n4;
    logic [NIBBLE_W-1:0] out_n5;
    logic [OPT_W-1:0]    out_opt;
    logic                out_equ;
    logic                abort;

    modport master (
        output in_valid, in_data, in_opt, in_equ, out_ready,
        input  in_ready, out_valid, out_n0, out_n1, out_n2, out_n3, out_n4, out_n5,
        input  out_opt, out_equ, abort
    );

    modport slave (
        input  in_valid, in_data, in_opt, in_equ, out_ready,
        output in_ready, out_valid, out_n0, out_n1, out_n2, out_n3, out_n4, out_n5,
        output out_opt, out_equ, abort
    );

endinterface

// File: rtl/cc_gap_timer.sv
// Saturating count of consecutive idle cycles; expire holds while the count
// sits at LIMIT and drops once clear is applied.
module cc_gap_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic clear,
    output logic expire
);

    localparam int unsigned GapW = $clog2(LIMIT + 1);

    logic [GapW-1:0] gap_q, gap_d;

    always_comb begin
        gap_d = gap_q;
        if (clear) begin
            gap_d = '0;
        end else if (count_en && (gap_q != GapW'(LIMIT))) begin
            gap_d = gap_q + GapW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

    assign expire = (gap_q == GapW'(LIMIT));

endmodule

// File: rtl/cc_in_collector.sv
// Serial-to-parallel collector feeding the CC core: six nibble beats in, one held bundle out.
// Optional idle-gap abort is enabled with the CC_IN_TIMEOUT_EN macro.
module cc_in_collector #(
    parameter int unsigned NUM_OF_ELEMENT = 6,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic              clk,
    input logic              rst_n,
    cc_in_collector_if.slave bus
);
    import cc_pkg::*;

    cc_in_state_t        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NIBBLE_W-1:0] slot_q [NUM_OF_ELEMENT];
    logic [OPT_W-1:0]    opt_q;
    logic                equ_q;
    logic                out_valid_q;

    logic accept;
    logic last_beat;
    logic expire;
    logic in_ready;
    logic abort;

    assign accept    = bus.in_valid && in_ready;
    assign last_beat = (cnt_q == CNT_W'(NUM_OF_ELEMENT - 1));

`ifdef CC_IN_TIMEOUT_EN
    logic gap_count;
    logic gap_clear;

    // Only LOAD idles count; leaving LOAD or taking a beat restarts the gap.
    assign gap_count = (state_q == StLoad) && !bus.in_valid;
    assign gap_clear = (state_q != StLoad) || accept;

    cc_gap_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_en (gap_count),
        .clear    (gap_clear),
        .expire   (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (expire) begin
                    state_d = StIdle;
                end else if (accept && last_beat) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; expire is registered inside the timer.
    always_comb begin
        in_ready = 1'b0;
        abort    = 1'b0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StLoad: begin
                in_ready = !expire;
                abort    = expire;
            end
            StHold: in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
    end

    // Beat counter: slot index of the next accepted beat.
    always_comb begin
        cnt_d = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d = CNT_W'(1);
                end
            end
            StLoad: begin
                if (expire || (accept && last_beat)) begin
                    cnt_d = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHold: cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= (state_d == StHold);
        end
    end

    // Data registers are never cleared outside reset; they only change on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_OF_ELEMENT); i++) begin
                slot_q[i] <= '0;
            end
            opt_q <= '0;
            equ_q <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < int'(NUM_OF_ELEMENT); i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    slot_q[i] <= bus.in_data;
                end
            end
            if (state_q == StIdle) begin
                opt_q <= bus.in_opt;
                equ_q <= bus.in_equ;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.abort     = abort;
    assign bus.out_valid = out_valid_q;
    assign bus.out_n0    = slot_q[0];
    assign bus.out_n1    = slot_q[1];
    assign bus.out_n2    = slot_q[2];
    assign bus.out_n3    = slot_q[3];
    assign bus.out_n4    = slot_q[4];
    assign bus.out_n5    = slot_q[5];
    assign bus.out_opt   = opt_q;
    assign bus.out_equ   = equ_q;

endmodule

// File: tb/tb_cc_in_collector.sv
// Directed bench for cc_in_collector: a per-cycle vector table plus hand-written
// sequences for hold, reset, gap, back-to-back and idle-timeout behaviour.
module tb_cc_in_collector;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cc_in_collector_if bus ();

    cc_in_collector #(
        .NUM_OF_ELEMENT (6),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic [2:0] o;
        logic       e;
        logic       r;
        logic       x_ir;
        logic       x_ov;
        logic       x_ab;
        logic       chk_b;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bundle(input string tag, input logic [23:0] nib, input logic [2:0] opt,
                              input logic equ);
        logic [23:0] act;
        act = {bus.out_n0, bus.out_n1, bus.out_n2, bus.out_n3, bus.out_n4, bus.out_n5};
        chk({tag, "_nibbles"}, {8'h0, act}, {8'h0, nib});
        chk({tag, "_opt"}, {29'h0, bus.out_opt}, {29'h0, opt});
        chk({tag, "_equ"}, {31'h0, bus.out_equ}, {31'h0, equ});
    endtask

    task automatic chk_ctl(input string tag, input logic ir, input logic ov, input logic ab);
        chk({tag, "_in_ready"}, {31'h0, bus.in_ready}, {31'h0, ir});
        chk({tag, "_out_valid"}, {31'h0, bus.out_valid}, {31'h0, ov});
        chk({tag, "_abort"}, {31'h0, bus.abort}, {31'h0, ab});
    endtask

    // Apply inputs just after a rising edge, then wait to mid-cycle for sampling.
    task automatic drive(input logic v, input logic [3:0] d, input logic [2:0] o, input logic e,
                         input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_opt    = o;
        bus.in_equ    = e;
        bus.out_ready = r;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input string tag, input logic [23:0] nib, input logic [2:0] opt,
                            input logic equ, input int gap);
        logic [3:0] d;
        for (int i = 0; i < 6; i++) begin
            d = nib[23 - 4 * i -: 4];
            if (i == 0) drive(1'b1, d, opt, equ, 1'b0);
            else        drive(1'b1, d, (i % 2 == 1) ? 3'd7 : 3'd0, ~equ, 1'b0);
            chk_ctl({tag, "_beat"}, 1'b1, 1'b0, 1'b0);
            tick();
            if (i < 5) begin
                for (int g = 0; g < gap; g++) begin
                    drive(1'b0, 4'h0, 3'd7, ~equ, 1'b0);
                    chk_ctl({tag, "_gap"}, 1'b1, 1'b0, 1'b0);
                    tick();
                end
            end
        end
    endtask

    task automatic release_hold(input string tag);
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b1);
        chk_ctl({tag, "_rel"}, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
        chk_ctl({tag, "_idle"}, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] two_pkts;
        logic        hold;
        int          k;

        checks = 0;
        errors = 0;

        //          v  d     o     e  r  ir ov ab chk_b
        tbl[0]  = '{1, 4'd3, 3'd5, 1, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 4'd1, 3'd2, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{1, 4'd4, 3'd7, 0, 0, 1, 0, 0, 0};
        tbl[3]  = '{1, 4'd1, 3'd0, 0, 0, 1, 0, 0, 0};
        tbl[4]  = '{1, 4'd5, 3'd2, 0, 0, 1, 0, 0, 0};
        tbl[5]  = '{1, 4'd9, 3'd2, 0, 0, 1, 0, 0, 0};
        tbl[6]  = '{1, 4'd7, 3'd2, 0, 0, 0, 1, 0, 1};
        tbl[7]  = '{1, 4'd7, 3'd2, 0, 0, 0, 1, 0, 1};
        tbl[8]  = '{1, 4'd7, 3'd2, 0, 1, 0, 1, 0, 1};
        tbl[9]  = '{0, 4'd0, 3'd0, 0, 0, 1, 0, 0, 1};
        tbl[10] = '{0, 4'd0, 3'd0, 0, 1, 1, 0, 0, 1};
        tbl[11] = '{0, 4'd0, 3'd0, 0, 0, 1, 0, 0, 1};

        // Reset values
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_opt = '0; bus.in_equ = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_ctl("reset", 1'b1, 1'b0, 1'b0);
        chk_bundle("reset", 24'h0, 3'd0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Back-to-back packet, short hold, release, data retained in IDLE
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].o, tbl[i].e, tbl[i].r);
            chk_ctl($sformatf("tbl%0d", i), tbl[i].x_ir, tbl[i].x_ov, tbl[i].x_ab);
            if (tbl[i].chk_b) chk_bundle($sformatf("tbl%0d", i), 24'h314159, 3'd5, 1'b1);
            tick();
        end

        // Long hold: ten cycles with out_ready low and a 7th beat offered
        send_pkt("hold", 24'h314159, 3'd5, 1'b1, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'hC, 3'd0, 1'b0, 1'b0);
            chk_ctl("hold_wait", 1'b0, 1'b1, 1'b0);
            chk_bundle("hold_wait", 24'h314159, 3'd5, 1'b1);
            tick();
        end
        release_hold("hold");

        // Two-cycle gaps; later beats carry different opt/equ that must be ignored
        send_pkt("gap", 24'h271828, 3'd2, 1'b0, 2);
        drive(1'b0, 4'h0, 3'd7, 1'b1, 1'b0);
        chk_ctl("gap_out", 1'b0, 1'b1, 1'b0);
        chk_bundle("gap_out", 24'h271828, 3'd2, 1'b0);
        tick();
        release_hold("gap");

        // Reset after three beats, then a fresh packet
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i + 1), 3'd4, 1'b1, 1'b0);
            tick();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_ctl("midrst", 1'b1, 1'b0, 1'b0);
        chk_bundle("midrst", 24'h0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_pkt("postrst", 24'hFEDCBA, 3'd1, 1'b0, 0);
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
        chk_ctl("postrst_out", 1'b0, 1'b1, 1'b0);
        chk_bundle("postrst_out", 24'hFEDCBA, 3'd1, 1'b0);
        tick();
        release_hold("postrst");

        // Two packets with out_ready high: out_valid one cycle each, period 7
        two_pkts = 48'h123456_654321;
        k = 0;
        for (int c = 0; c < 15; c++) begin
            hold = (c == 6) || (c == 13);
            drive((k < 12) ? 1'b1 : 1'b0, (k < 12) ? two_pkts[47 - 4 * k -: 4] : 4'h0,
                  (k == 0) ? 3'd3 : (k == 6) ? 3'd6 : 3'd1, (k == 6) ? 1'b1 : 1'b0, 1'b1);
            chk_ctl($sformatf("b2b_c%0d", c), ~hold, hold, 1'b0);
            if (c == 6)  chk_bundle("b2b_a", 24'h123456, 3'd3, 1'b0);
            if (c == 13) chk_bundle("b2b_b", 24'h654321, 3'd6, 1'b1);
            if (!hold && k < 12) k++;
            tick();
        end

        // Two beats then fifteen idle cycles
        drive(1'b1, 4'hA, 3'd4, 1'b1, 1'b0); tick();
        drive(1'b1, 4'hB, 3'd0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
            chk_ctl("idle_gap", 1'b1, 1'b0, 1'b0);
            tick();
        end
`ifdef CC_IN_TIMEOUT_EN
        drive(1'b1, 4'hE, 3'd7, 1'b0, 1'b0);
        chk_ctl("timeout", 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
        chk_ctl("after_to", 1'b1, 1'b0, 1'b0);
        chk({"after_to", "_n0"}, {28'h0, bus.out_n0}, 32'hA);
        chk({"after_to", "_n1"}, {28'h0, bus.out_n1}, 32'hB);
        tick();
        send_pkt("to_next", 24'h0F1E2D, 3'd2, 1'b0, 0);
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
        chk_ctl("to_next_out", 1'b0, 1'b1, 1'b0);
        chk_bundle("to_next_out", 24'h0F1E2D, 3'd2, 1'b0);
        tick();
        release_hold("to_next");
`else
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(12 + i), 3'd7, 1'b0, 1'b0);
            chk_ctl("resume", 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b0);
        chk_ctl("resume_out", 1'b0, 1'b1, 1'b0);
        chk_bundle("resume_out", 24'hABCDEF, 3'd4, 1'b1);
        tick();
        release_hold("resume");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
